// File: rtl/sram_ctrl_pkg.sv
// Shared encodings and packet field offsets for the SRAM packet controller.
// Packet layout, MSB first: op | sel | wmask | addr | din.
`timescale 1ns/1ps
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ0 = 2'd2,
        OP_READ1 = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam int OP_W = 2;

    function automatic int din_lsb();
        return 0;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int wmask_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int sel_lsb(input int nwm, input int addr_w, input int data_w);
        return nwm + addr_w + data_w;
    endfunction

    function automatic int op_lsb(input int sel_w, input int nwm, input int addr_w,
                                  input int data_w);
        return sel_w + nwm + addr_w + data_w;
    endfunction

    function automatic int pkt_width(input int sel_w, input int nwm, input int addr_w,
                                     input int data_w);
        return OP_W + sel_w + nwm + addr_w + data_w;
    endfunction

endpackage

// File: rtl/sram_packet_ctrl.sv
// Packet-driven controller for a bank of 1rw1r SRAM macros: one command at a
// time, every SRAM-side and pico-side output registered.
//
// state      | meaning
// IDLE       | pkt_ready high, waiting for a packet
// ISSUE      | chip select / write enable active for one cycle
// WAIT       | read data in flight (READ_LATENCY-1 cycles)
// CAPTURE    | selected dout slice sampled into resp_data
// RESP       | response pulse scheduled, back to IDLE next
`timescale 1ns/1ps
module sram_packet_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WMASKS   = 4,
    parameter int NUM_MACROS   = 2,
    parameter int READ_LATENCY = 1,
    localparam int SEL_W = $clog2(NUM_MACROS),
    localparam int PKT_W = pkt_width(SEL_W, NUM_WMASKS, ADDR_WIDTH, DATA_WIDTH)
) (
    input  logic                             clk_in,
    input  logic                             rst,
    input  logic                             pkt_valid,
    output logic                             pkt_ready,
    input  logic [PKT_W-1:0]                 packet,
    output logic [NUM_MACROS-1:0]            csb0,
    output logic                             web0,
    output logic [NUM_WMASKS-1:0]            wmask0,
    output logic [ADDR_WIDTH-1:0]            addr0,
    output logic [DATA_WIDTH-1:0]            din0,
    output logic [NUM_MACROS-1:0]            csb1,
    output logic [ADDR_WIDTH-1:0]            addr1,
    input  logic [NUM_MACROS*DATA_WIDTH-1:0] dout0,
    input  logic [NUM_MACROS*DATA_WIDTH-1:0] dout1,
    output logic                             resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             resp_err
);

    localparam int OP_LSB    = op_lsb(SEL_W, NUM_WMASKS, ADDR_WIDTH, DATA_WIDTH);
    localparam int SEL_LSB   = sel_lsb(NUM_WMASKS, ADDR_WIDTH, DATA_WIDTH);
    localparam int WMASK_LSB = wmask_lsb(ADDR_WIDTH, DATA_WIDTH);
    localparam int ADDR_LSB  = addr_lsb(DATA_WIDTH);
    localparam int DIN_LSB   = din_lsb();

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        CNT_W'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);
    localparam logic [SEL_W:0]        MACROS_L = (SEL_W + 1)'(NUM_MACROS);
    localparam logic [NUM_MACROS-1:0] CSB_IDLE = '1;
    localparam logic [NUM_MACROS-1:0] CSB_ONE  = NUM_MACROS'(1);

    state_t                  r_state;
    op_t                     r_op;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_bad;
    logic [CNT_W-1:0]        r_wait_cnt;
    logic                    r_pkt_ready;
    logic [NUM_MACROS-1:0]   r_csb0;
    logic [NUM_MACROS-1:0]   r_csb1;
    logic                    r_web0;
    logic [NUM_WMASKS-1:0]   r_wmask0;
    logic [ADDR_WIDTH-1:0]   r_addr0;
    logic [DATA_WIDTH-1:0]   r_din0;
    logic [ADDR_WIDTH-1:0]   r_addr1;
    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_data;
    logic                    r_resp_err;

    op_t                     w_op;
    logic [SEL_W-1:0]        w_sel;
    logic [NUM_WMASKS-1:0]   w_wmask;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_din;
    logic                    w_sel_ok;
    logic [NUM_MACROS-1:0]   w_csb_sel;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign w_op      = op_t'(packet[OP_LSB +: OP_W]);
    assign w_sel     = packet[SEL_LSB +: SEL_W];
    assign w_wmask   = packet[WMASK_LSB +: NUM_WMASKS];
    assign w_addr    = packet[ADDR_LSB +: ADDR_WIDTH];
    assign w_din     = packet[DIN_LSB +: DATA_WIDTH];
    assign w_sel_ok  = ({1'b0, w_sel} < MACROS_L);
    assign w_csb_sel = ~(CSB_ONE << w_sel);

    // Read port follows the latched op; READ1 reads port1, everything else port0.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < NUM_MACROS; k++) begin
            if (r_sel == SEL_W'(k)) begin
                w_rd_word = (r_op == OP_READ1) ? dout1[k*DATA_WIDTH +: DATA_WIDTH]
                                               : dout0[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_NOP;
            r_sel        <= '0;
            r_bad        <= 1'b0;
            r_wait_cnt   <= '0;
            r_pkt_ready  <= 1'b1;
            r_csb0       <= CSB_IDLE;
            r_csb1       <= CSB_IDLE;
            r_web0       <= 1'b1;
            r_wmask0     <= '0;
            r_addr0      <= '0;
            r_din0       <= '0;
            r_addr1      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            // Strobes default inactive so the SRAM is only touched during ISSUE.
            r_csb0       <= CSB_IDLE;
            r_csb1       <= CSB_IDLE;
            r_web0       <= 1'b1;
            r_resp_valid <= 1'b0;
            r_pkt_ready  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (pkt_valid && (w_op != OP_NOP)) begin
                        r_op  <= w_op;
                        r_sel <= w_sel;
                        r_bad <= !w_sel_ok;
                        if (!w_sel_ok) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_ISSUE;
                            case (w_op)
                                OP_WRITE: begin
                                    r_csb0   <= w_csb_sel;
                                    r_web0   <= 1'b0;
                                    r_wmask0 <= w_wmask;
                                    r_addr0  <= w_addr;
                                    r_din0   <= w_din;
                                end
                                OP_READ0: begin
                                    r_csb0  <= w_csb_sel;
                                    r_addr0 <= w_addr;
                                end
                                OP_READ1: begin
                                    r_csb1  <= w_csb_sel;
                                    r_addr1 <= w_addr;
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        r_pkt_ready <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    if (r_op == OP_WRITE) begin
                        r_state <= ST_RESP;
                    end else if (READ_LATENCY <= 1) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_wait_cnt <= WAIT_LOAD;
                        r_state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    r_resp_data <= w_rd_word;
                    r_state     <= ST_RESP;
                end

                ST_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= r_bad;
                    r_pkt_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_pkt_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign pkt_ready  = r_pkt_ready;
    assign csb0       = r_csb0;
    assign csb1       = r_csb1;
    assign web0       = r_web0;
    assign wmask0     = r_wmask0;
    assign addr0      = r_addr0;
    assign din0       = r_din0;
    assign addr1      = r_addr1;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_sram_packet_ctrl.sv
// Directed bench: instance A uses defaults, instance B has three macros and
// READ_LATENCY=3 for the wait-state, bad-select and mid-operation reset cases.
`timescale 1ns/1ps
module tb_sram_packet_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // instance A: NUM_MACROS=2, READ_LATENCY=1, PKT_W=47
    logic        pv_a, pr_a, web0_a, rv_a, re_a;
    logic [46:0] pkt_a;
    logic [1:0]  csb0_a, csb1_a;
    logic [3:0]  wm_a;
    logic [7:0]  ad0_a, ad1_a;
    logic [31:0] di0_a, rd_a;
    logic [63:0] do0_a, do1_a;

    // instance B: NUM_MACROS=3, READ_LATENCY=3, PKT_W=48
    logic        pv_b, pr_b, web0_b, rv_b, re_b;
    logic [47:0] pkt_b;
    logic [2:0]  csb0_b, csb1_b;
    logic [3:0]  wm_b;
    logic [7:0]  ad0_b, ad1_b;
    logic [31:0] di0_b, rd_b;
    logic [95:0] do0_b, do1_b;

    sram_packet_ctrl u_dut_a (
        .clk_in(clk), .rst(rst), .pkt_valid(pv_a), .pkt_ready(pr_a), .packet(pkt_a),
        .csb0(csb0_a), .web0(web0_a), .wmask0(wm_a), .addr0(ad0_a), .din0(di0_a),
        .csb1(csb1_a), .addr1(ad1_a), .dout0(do0_a), .dout1(do1_a),
        .resp_valid(rv_a), .resp_data(rd_a), .resp_err(re_a)
    );

    sram_packet_ctrl #(.NUM_MACROS(3), .READ_LATENCY(3)) u_dut_b (
        .clk_in(clk), .rst(rst), .pkt_valid(pv_b), .pkt_ready(pr_b), .packet(pkt_b),
        .csb0(csb0_b), .web0(web0_b), .wmask0(wm_b), .addr0(ad0_b), .din0(di0_b),
        .csb1(csb1_b), .addr1(ad1_b), .dout0(do0_b), .dout1(do1_b),
        .resp_valid(rv_b), .resp_data(rd_b), .resp_err(re_b)
    );

    function automatic logic [46:0] mk_a(input logic [1:0] op, input logic sel,
                                         input logic [3:0] wm, input logic [7:0] ad,
                                         input logic [31:0] d);
        return {op, sel, wm, ad, d};
    endfunction

    function automatic logic [47:0] mk_b(input logic [1:0] op, input logic [1:0] sel,
                                         input logic [3:0] wm, input logic [7:0] ad,
                                         input logic [31:0] d);
        return {op, sel, wm, ad, d};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (csb0_a !== 2'b11) begin n_errors++; $display("FAIL rst_csb0 got %b exp 11", csb0_a); end
        n_checks++; if (csb1_a !== 2'b11) begin n_errors++; $display("FAIL rst_csb1 got %b exp 11", csb1_a); end
        n_checks++; if (web0_a !== 1'b1) begin n_errors++; $display("FAIL rst_web0 got %b exp 1", web0_a); end
        n_checks++; if ({wm_a, ad0_a, di0_a, ad1_a} !== 52'd0) begin n_errors++; $display("FAIL rst_buses got %h exp 0", {wm_a, ad0_a, di0_a, ad1_a}); end
        n_checks++; if ({rv_a, re_a, rd_a} !== 34'd0) begin n_errors++; $display("FAIL rst_resp got %h exp 0", {rv_a, re_a, rd_a}); end
        n_checks++; if (csb0_b !== 3'b111) begin n_errors++; $display("FAIL rst_csb0_b got %b exp 111", csb0_b); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (pr_a !== 1'b1) begin n_errors++; $display("FAIL rst_ready got %b exp 1", pr_a); end
    endtask

    task automatic test_write();
        @(negedge clk);
        pkt_a = mk_a(2'd1, 1'b1, 4'hF, 8'h2A, 32'hDEADBEEF);
        pv_a  = 1'b1;
        @(posedge clk); #1;   // edge T
        pv_a = 1'b0;
        n_checks++; if (csb0_a !== 2'b01) begin n_errors++; $display("FAIL wr_csb0 got %b exp 01", csb0_a); end
        n_checks++; if (web0_a !== 1'b0) begin n_errors++; $display("FAIL wr_web0 got %b exp 0", web0_a); end
        n_checks++; if ({wm_a, ad0_a, di0_a} !== {4'hF, 8'h2A, 32'hDEADBEEF}) begin n_errors++; $display("FAIL wr_bus got %h exp f2adeadbeef", {wm_a, ad0_a, di0_a}); end
        n_checks++; if (csb1_a !== 2'b11) begin n_errors++; $display("FAIL wr_csb1 got %b exp 11", csb1_a); end
        n_checks++; if (pr_a !== 1'b0) begin n_errors++; $display("FAIL wr_ready got %b exp 0", pr_a); end
        @(posedge clk); #1;   // T+1
        n_checks++; if ({csb0_a, web0_a, rv_a} !== 4'b1110) begin n_errors++; $display("FAIL wr_t1 got %b exp 1110", {csb0_a, web0_a, rv_a}); end
        @(posedge clk); #1;   // T+2
        n_checks++; if ({rv_a, re_a} !== 2'b10) begin n_errors++; $display("FAIL wr_resp got %b exp 10", {rv_a, re_a}); end
        n_checks++; if (rd_a !== 32'd0) begin n_errors++; $display("FAIL wr_data got %h exp 0", rd_a); end
        n_checks++; if (pr_a !== 1'b1) begin n_errors++; $display("FAIL wr_ready2 got %b exp 1", pr_a); end
        @(posedge clk); #1;
        n_checks++; if (rv_a !== 1'b0) begin n_errors++; $display("FAIL wr_pulse got %b exp 0", rv_a); end
    endtask

    task automatic test_read0();
        @(negedge clk);
        pkt_a = mk_a(2'd2, 1'b1, 4'h0, 8'h2A, 32'h0);
        pv_a  = 1'b1;
        @(posedge clk); #1;   // edge T
        pv_a = 1'b0;
        n_checks++; if ({csb0_a, web0_a, csb1_a} !== 5'b01111) begin n_errors++; $display("FAIL rd0_issue got %b exp 01111", {csb0_a, web0_a, csb1_a}); end
        n_checks++; if (ad0_a !== 8'h2A) begin n_errors++; $display("FAIL rd0_addr got %h exp 2a", ad0_a); end
        n_checks++; if ({wm_a, di0_a} !== {4'hF, 32'hDEADBEEF}) begin n_errors++; $display("FAIL rd0_hold got %h exp fdeadbeef", {wm_a, di0_a}); end
        @(posedge clk); #1;   // T+1
        n_checks++; if ({csb0_a, rv_a} !== 3'b110) begin n_errors++; $display("FAIL rd0_t1 got %b exp 110", {csb0_a, rv_a}); end
        @(posedge clk); #1;   // T+2
        n_checks++; if (rv_a !== 1'b0) begin n_errors++; $display("FAIL rd0_early got %b exp 0", rv_a); end
        @(posedge clk); #1;   // T+3
        n_checks++; if ({rv_a, re_a} !== 2'b10) begin n_errors++; $display("FAIL rd0_resp got %b exp 10", {rv_a, re_a}); end
        n_checks++; if (rd_a !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd0_data got %h exp deadbeef", rd_a); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        @(negedge clk);
        pkt_a = mk_a(2'd1, 1'b0, 4'h3, 8'h05, 32'h00001111);
        pv_a  = 1'b1;
        @(posedge clk); #1;   // T: write accepted
        n_checks++; if ({csb0_a, web0_a} !== 3'b100) begin n_errors++; $display("FAIL b2b_wr got %b exp 100", {csb0_a, web0_a}); end
        pkt_a = mk_a(2'd2, 1'b0, 4'h0, 8'h06, 32'h0);
        @(posedge clk); #1;   // T+1
        n_checks++; if ({csb0_a, pr_a} !== 3'b110) begin n_errors++; $display("FAIL b2b_ignored got %b exp 110", {csb0_a, pr_a}); end
        @(posedge clk); #1;   // T+2: ack, IDLE
        n_checks++; if ({rv_a, re_a, pr_a, csb0_a} !== 5'b10111) begin n_errors++; $display("FAIL b2b_ack got %b exp 10111", {rv_a, re_a, pr_a, csb0_a}); end
        @(posedge clk); #1;   // T+3: read accepted
        n_checks++; if ({csb0_a, web0_a, ad0_a} !== {2'b10, 1'b1, 8'h06}) begin n_errors++; $display("FAIL b2b_rd got %h exp 506", {csb0_a, web0_a, ad0_a}); end
        pkt_a = mk_a(2'd0, 1'b1, 4'hF, 8'h77, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (rv_a !== 1'b0) begin n_errors++; $display("FAIL b2b_rd_early got %b exp 0", rv_a); end
        @(posedge clk); #1;   // T+6
        n_checks++; if ({rv_a, rd_a} !== {1'b1, 32'h12345678}) begin n_errors++; $display("FAIL b2b_rd_resp got %h exp 112345678", {rv_a, rd_a}); end
        @(posedge clk); #1;   // T+7: NOP consumed
        n_checks++; if ({rv_a, pr_a, csb0_a, csb1_a} !== 6'b011111) begin n_errors++; $display("FAIL b2b_nop got %b exp 011111", {rv_a, pr_a, csb0_a, csb1_a}); end
        pv_a = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rv_a === 1'b1 || csb0_a !== 2'b11) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL b2b_nop_quiet got %0d exp 0", pulses); end
    endtask

    task automatic test_read1();
        @(negedge clk);
        pkt_b = mk_b(2'd3, 2'd0, 4'h0, 8'hFF, 32'h0);
        pv_b  = 1'b1;
        @(posedge clk); #1;   // edge T
        pv_b = 1'b0;
        n_checks++; if ({csb1_b, csb0_b, web0_b} !== 7'b1101111) begin n_errors++; $display("FAIL rd1_issue got %b exp 1101111", {csb1_b, csb0_b, web0_b}); end
        n_checks++; if (ad1_b !== 8'hFF) begin n_errors++; $display("FAIL rd1_addr got %h exp ff", ad1_b); end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            n_checks++; if ({rv_b, csb1_b} !== 4'b0111) begin n_errors++; $display("FAIL rd1_wait%0d got %b exp 0111", k, {rv_b, csb1_b}); end
        end
        @(posedge clk); #1;   // T+5
        n_checks++; if ({rv_b, re_b, rd_b} !== {2'b10, 32'hCAFEF00D}) begin n_errors++; $display("FAIL rd1_resp got %h exp 2cafef00d", {rv_b, re_b, rd_b}); end
    endtask

    task automatic test_bad_sel();
        @(negedge clk);
        pkt_b = mk_b(2'd2, 2'd3, 4'h0, 8'h01, 32'h0);
        pv_b  = 1'b1;
        @(posedge clk); #1;   // edge T
        pv_b = 1'b0;
        n_checks++; if ({csb0_b, csb1_b, web0_b, pr_b} !== 8'b11111110) begin n_errors++; $display("FAIL bad_nocs got %b exp 11111110", {csb0_b, csb1_b, web0_b, pr_b}); end
        @(posedge clk); #1;   // T+1
        n_checks++; if ({rv_b, re_b} !== 2'b11) begin n_errors++; $display("FAIL bad_resp got %b exp 11", {rv_b, re_b}); end
        n_checks++; if (rd_b !== 32'hCAFEF00D) begin n_errors++; $display("FAIL bad_data got %h exp cafef00d", rd_b); end
        n_checks++; if ({csb0_b, csb1_b} !== 6'b111111) begin n_errors++; $display("FAIL bad_nocs2 got %b exp 111111", {csb0_b, csb1_b}); end
        @(posedge clk); #1;
        n_checks++; if ({rv_b, pr_b} !== 2'b01) begin n_errors++; $display("FAIL bad_end got %b exp 01", {rv_b, pr_b}); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        pkt_b = mk_b(2'd2, 2'd1, 4'h0, 8'h10, 32'h0);
        pv_b  = 1'b1;
        @(posedge clk); #1;   // edge T
        pv_b = 1'b0;
        n_checks++; if (csb0_b !== 3'b101) begin n_errors++; $display("FAIL mid_issue got %b exp 101", csb0_b); end
        @(posedge clk); #1;   // T+1: in WAIT
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({csb0_b, csb1_b, web0_b} !== 7'b1111111) begin n_errors++; $display("FAIL mid_strobes got %b exp 1111111", {csb0_b, csb1_b, web0_b}); end
        n_checks++; if ({rv_b, re_b, rd_b} !== 34'd0) begin n_errors++; $display("FAIL mid_resp got %h exp 0", {rv_b, re_b, rd_b}); end
        n_checks++; if ({ad0_b, ad1_b} !== 16'd0) begin n_errors++; $display("FAIL mid_addr got %h exp 0", {ad0_b, ad1_b}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (pr_b !== 1'b1) begin n_errors++; $display("FAIL mid_ready got %b exp 1", pr_b); end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (rv_b === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL mid_no_pulse got %0d exp 0", pulses); end
    endtask

    initial begin
        rst   = 1'b1;
        pv_a  = 1'b0;
        pv_b  = 1'b0;
        pkt_a = '0;
        pkt_b = '0;
        do0_a = {32'hDEADBEEF, 32'h12345678};
        do1_a = {32'hAAAA5555, 32'h5555AAAA};
        do0_b = {32'h0B0B0B0B, 32'h77777777, 32'h0BADBAD0};
        do1_b = {32'h33333333, 32'h22222222, 32'hCAFEF00D};
        repeat (2) @(posedge clk);
        test_reset();
        test_write();
        test_read0();
        test_back_to_back();
        test_read1();
        test_bad_sel();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
